// File: rtl/soc_bus_pkg.sv
// Shared types and default sizing for the single-outstanding SoC bus fabric.
package soc_bus_pkg;

  localparam int DEF_N_SLAVES       = 4;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Saturating 8-bit increment used by the fault counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/soc_bus_decoder.sv
// Address decoder: base/mask match, lowest-index priority, read-only write check.
module soc_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int                          N_SLAVES   = DEF_N_SLAVES,
  parameter int                          ADDR_W     = DEF_ADDR_W,
  parameter int                          SEL_W      = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK = '1,
  parameter logic [N_SLAVES-1:0]         SLAVE_RO   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              is_write_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              ro_viol_o
);

  logic sel_ro;

  // Scan from the top index down so the lowest matching slave is the one left standing.
  always_comb begin
    hit_o  = 1'b0;
    sel_o  = '0;
    sel_ro = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_o  = 1'b1;
        sel_o  = SEL_W'(i);
        sel_ro = SLAVE_RO[i];
      end
    end
  end

  // A write landing on a read-only slave is refused before the slave is ever strobed.
  always_comb begin
    ro_viol_o = hit_o & is_write_i & sel_ro;
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master to N-slave bus fabric with one transaction in flight,
// slave timeout, and fault capture.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for m_valid_i; request latched and decoded here
// ST_ACTIVE | s_valid_o[sel] held until s_ready or timeout
// ST_RESP   | m_ready_o pulses for one cycle with m_rdata_o / m_fault_o
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                          N_SLAVES       = DEF_N_SLAVES,
  parameter int                          ADDR_W         = DEF_ADDR_W,
  parameter int                          DATA_W         = DEF_DATA_W,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_BASE     = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]  SLAVE_MASK     = '1,
  parameter logic [N_SLAVES-1:0]         SLAVE_RO       = '0,
  parameter int                          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       m_valid_i,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic [DATA_W/8-1:0]        m_wstrb_i,
  input  logic [DATA_W-1:0]          m_wdata_i,
  output logic                       m_ready_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       m_fault_o,
  output logic [N_SLAVES-1:0]        s_valid_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W/8-1:0]        s_wstrb_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
  input  logic [N_SLAVES-1:0]        s_ready_i,
  output logic [ADDR_W-1:0]          fault_addr_o,
  output logic [7:0]                 fault_count_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;

  logic              dec_hit;
  logic [SEL_W-1:0]  dec_sel;
  logic              dec_ro_viol;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready;

  soc_bus_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .SLAVE_RO   (SLAVE_RO)
  ) u_decoder (
    .addr_i     (m_addr_i),
    .is_write_i (|m_wstrb_i),
    .hit_o      (dec_hit),
    .sel_o      (dec_sel),
    .ro_viol_o  (dec_ro_viol)
  );

  // Pick the selected slave's data and completion; other slaves are invisible.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_rdata = s_rdata_i[i*DATA_W +: DATA_W];
        sel_ready = s_ready_i[i];
      end
    end
  end

  // Next-state and datapath updates for the three-state transaction FSM.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_valid_i) begin
          addr_d  = m_addr_i;
          wstrb_d = m_wstrb_i;
          wdata_d = m_wdata_i;
          cnt_d   = '0;
          if (dec_hit && !dec_ro_viol) begin
            sel_d   = dec_sel;
            state_d = ST_ACTIVE;
          end else begin
            rdata_d      = '0;
            fault_d      = 1'b1;
            fault_addr_d = m_addr_i;
            fault_cnt_d  = sat_inc8(fault_cnt_q);
            state_d      = ST_RESP;
          end
        end
      end
      ST_ACTIVE: begin
        // Completion wins over timeout when both land in the same cycle.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          fault_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d      = '0;
          fault_d      = 1'b1;
          fault_addr_d = addr_q;
          fault_cnt_d  = sat_inc8(fault_cnt_q);
          cnt_d        = '0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  // Slave strobe is decoded straight from state so reset removes it immediately.
  always_comb begin
    s_valid_o = '0;
    if (state_q == ST_ACTIVE) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        s_valid_o[i] = (sel_q == SEL_W'(i));
      end
    end
  end

  assign m_ready_o     = (state_q == ST_RESP);
  assign m_rdata_o     = rdata_q;
  assign m_fault_o     = fault_q;
  assign s_addr_o      = addr_q;
  assign s_wstrb_o     = wstrb_q;
  assign s_wdata_o     = wdata_q;
  assign fault_addr_o  = fault_addr_q;
  assign fault_count_o = fault_cnt_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric with three slaves and an 8-cycle timeout.
module tb_soc_bus_fabric;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [N*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASK = {32'hFF00_0000, 32'hFFFF_FFF0, 32'hFFFF_0000};
  localparam logic [N-1:0]    RO   = 3'b100;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_valid;
  logic [AW-1:0]   m_addr;
  logic [DW/8-1:0] m_wstrb;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic            m_fault;
  logic [N-1:0]    s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW/8-1:0] s_wstrb;
  logic [DW-1:0]   s_wdata;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic [AW-1:0]   fault_addr;
  logic [7:0]      fault_count;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic [N-1:0] sv_or;
  int sv0_cnt;
  int mr_cnt;

  soc_bus_fabric #(
    .N_SLAVES       (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SLAVE_BASE     (BASE),
    .SLAVE_MASK     (MASK),
    .SLAVE_RO       (RO),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .m_valid_i     (m_valid),
    .m_addr_i      (m_addr),
    .m_wstrb_i     (m_wstrb),
    .m_wdata_i     (m_wdata),
    .m_ready_o     (m_ready),
    .m_rdata_o     (m_rdata),
    .m_fault_o     (m_fault),
    .s_valid_o     (s_valid),
    .s_addr_o      (s_addr),
    .s_wstrb_o     (s_wstrb),
    .s_wdata_o     (s_wdata),
    .s_rdata_i     (s_rdata),
    .s_ready_i     (s_ready),
    .fault_addr_o  (fault_addr),
    .fault_count_o (fault_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    sv_or = sv_or | s_valid;
    if (s_valid[0]) sv0_cnt = sv0_cnt + 1;
    if (m_ready) mr_cnt = mr_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; lat counts clock edges from the sampling edge to m_ready.
  task automatic do_req(input logic [AW-1:0] addr, input logic [3:0] strb,
                        input logic [DW-1:0] wdata, input int rdy_at,
                        input logic [N-1:0] rdy_mask, output int lat_o);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wstrb = strb;
    m_wdata = wdata;
    lat_o   = 0;
    if (rdy_at == 0) s_ready = rdy_mask;
    while (lat_o < 50) begin
      step();
      lat_o++;
      if (m_ready) break;
      if (lat_o == rdy_at) s_ready = rdy_mask;
    end
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  initial begin
    reset   = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wstrb = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = {32'h2222_0002, 32'hA5A5_0001, 32'h0000_0A0A};
    sv_or   = '0;
    sv0_cnt = 0;
    mr_cnt  = 0;
    #2;
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_fault", 64'(m_fault), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_fault_addr", 64'(fault_addr), 64'd0);
    chk("rst_fault_count", 64'(fault_count), 64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Read S1 with immediate completion.
    sv_or = '0;
    do_req(32'h1000_0004, 4'h0, 32'h0, 0, 3'b010, lat);
    chk("s1_rd_latency", 64'(lat), 64'd2);
    chk("s1_rd_rdata", 64'(m_rdata), 64'hA5A5_0001);
    chk("s1_rd_fault", 64'(m_fault), 64'd0);
    chk("s1_rd_s_addr", 64'(s_addr), 64'h1000_0004);
    step();
    chk("s1_rd_ready_one_cycle", 64'(m_ready), 64'd0);
    chk("s1_rd_rdata_hold", 64'(m_rdata), 64'hA5A5_0001);
    chk("s1_rd_only_sv1", 64'(sv_or), 64'b010);

    // Write to read-only S2 is refused without touching the slave.
    sv_or = '0;
    do_req(32'h2000_0100, 4'hF, 32'hDEAD_BEEF, -1, 3'b000, lat);
    chk("ro_wr_latency", 64'(lat), 64'd1);
    chk("ro_wr_fault", 64'(m_fault), 64'd1);
    chk("ro_wr_rdata", 64'(m_rdata), 64'd0);
    chk("ro_wr_fault_addr", 64'(fault_addr), 64'h2000_0100);
    chk("ro_wr_fault_count", 64'(fault_count), 64'd1);
    step();
    chk("ro_wr_no_s_valid", 64'(sv_or), 64'd0);

    // Unmapped read.
    do_req(32'h3000_0000, 4'h0, 32'h0, -1, 3'b000, lat);
    chk("miss_latency", 64'(lat), 64'd1);
    chk("miss_fault", 64'(m_fault), 64'd1);
    chk("miss_rdata", 64'(m_rdata), 64'd0);
    chk("miss_fault_count", 64'(fault_count), 64'd2);
    step();

    // S0 never answers: eight strobe cycles then a timeout fault.
    sv0_cnt = 0;
    do_req(32'h0000_0010, 4'h0, 32'h0, -1, 3'b000, lat);
    chk("to_latency", 64'(lat), 64'd9);
    chk("to_fault", 64'(m_fault), 64'd1);
    chk("to_rdata", 64'(m_rdata), 64'd0);
    chk("to_fault_addr", 64'(fault_addr), 64'h0000_0010);
    chk("to_fault_count", 64'(fault_count), 64'd3);
    step();
    chk("to_sv0_cycles", 64'(sv0_cnt), 64'd8);
    mr_cnt  = 0;
    s_ready = 3'b001;
    repeat (4) step();
    s_ready = '0;
    chk("to_late_ready_ignored", 64'(mr_cnt), 64'd0);

    // Completion in the terminal timeout cycle wins.
    s_rdata = {32'h2222_0002, 32'hA5A5_0001, 32'h1234_5678};
    do_req(32'h0000_0020, 4'h0, 32'h0, 8, 3'b001, lat);
    chk("tc_ready_latency", 64'(lat), 64'd9);
    chk("tc_ready_fault", 64'(m_fault), 64'd0);
    chk("tc_ready_rdata", 64'(m_rdata), 64'h1234_5678);
    chk("tc_ready_fault_count", 64'(fault_count), 64'd3);
    step();

    // Non-selected completions are ignored; write to S1 succeeds.
    s_ready = 3'b101;
    do_req(32'h1000_0008, 4'h3, 32'h0000_CAFE, 3, 3'b111, lat);
    chk("s1_wr_latency", 64'(lat), 64'd4);
    chk("s1_wr_fault", 64'(m_fault), 64'd0);
    chk("s1_wr_s_wstrb", 64'(s_wstrb), 64'h3);
    chk("s1_wr_s_wdata", 64'(s_wdata), 64'h0000_CAFE);
    step();

    // Read of the read-only slave is allowed.
    do_req(32'h2000_0100, 4'h0, 32'h0, 0, 3'b100, lat);
    chk("s2_rd_latency", 64'(lat), 64'd2);
    chk("s2_rd_rdata", 64'(m_rdata), 64'h2222_0002);
    chk("s2_rd_fault", 64'(m_fault), 64'd0);
    step();

    // Reset in the third ACTIVE cycle.
    m_valid = 1'b1;
    m_addr  = 32'h0000_0010;
    m_wstrb = 4'h0;
    repeat (3) step();
    chk("rst_mid_s_valid_before", 64'(s_valid), 64'b001);
    mr_cnt = 0;
    reset  = 1'b1;
    m_valid = 1'b0;
    #1;
    chk("rst_mid_s_valid", 64'(s_valid), 64'd0);
    chk("rst_mid_m_ready", 64'(m_ready), 64'd0);
    chk("rst_mid_fault_count", 64'(fault_count), 64'd0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("rst_mid_no_response", 64'(mr_cnt), 64'd0);
    do_req(32'h1000_0004, 4'h0, 32'h0, 0, 3'b010, lat);
    chk("post_rst_latency", 64'(lat), 64'd2);
    chk("post_rst_rdata", 64'(m_rdata), 64'hA5A5_0001);
    chk("post_rst_fault", 64'(m_fault), 64'd0);
    step();

    // Fault counter saturation.
    for (int i = 0; i < 260; i++) begin
      do_req(32'h3000_0000 + 32'(i * 4), 4'h0, 32'h0, -1, 3'b000, lat);
      step();
      if (i == 254) chk("sat_count_at_255", 64'(fault_count), 64'd255);
    end
    chk("sat_count_final", 64'(fault_count), 64'd255);
    chk("sat_fault_addr", 64'(fault_addr), 64'h3000_040C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
